latch_bank_scheduler: RTL and testbench

Sequences and shares write access to a bank of cross-coupled gate-level latch cells (NAND-pair storage elements with feedback) among several requesters. Each request sets or clears one cell. The scheduler arbitrates round-robin, drives a set or reset pulse onto the selected cell, and holds off for a settle window while the feedback loop resolves. It then acknowledges the requester. It sits between the synchronous control logic and the asynchronous latch netlist, so no requester ever touches the cell drive lines directly.

---
 rtl/latch_bank_if.sv | 28 ++
 rtl/latch_bank_scheduler.sv | 161 ++++++++++++++++
 tb/tb_latch_bank_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_if.sv
// Requester/latch-bank bundle for latch_bank_scheduler.
// slave = scheduler side, master = requesters plus the latch netlist readback.
interface latch_bank_if #(
  parameter int NREQ  = 4,
  parameter int NCELL = 8,
  parameter int AW    = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic               busy;
  logic [NCELL-1:0]   cell_s;
  logic [NCELL-1:0]   cell_r;
  logic [NCELL-1:0]   cell_q;

  modport master (
    output req, req_op, req_addr, cell_q,
    input  gnt, done, err, busy, cell_s, cell_r
  );

  modport slave (
    input  req, req_op, req_addr, cell_q,
    output gnt, done, err, busy, cell_s, cell_r
  );
endinterface

// File: rtl/latch_bank_scheduler.sv
// Round-robin write scheduler for a bank of NAND-pair latches: pulse, settle, acknowledge.
// Optional readback verify with a single retry when LATCH_BANK_VERIFY_EN is defined.
module latch_bank_scheduler #(
  parameter int NREQ       = 4,
  parameter int NCELL      = 8,
  parameter int AW         = 3,
  parameter int DRIVE_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  latch_bank_if.slave bus
);

  localparam int PW = $clog2(NREQ);

`ifdef LATCH_BANK_VERIFY_EN
  typedef enum logic [2:0] {IDLE, GRANT, DRIVE, SETTLE, CHECK, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, GRANT, DRIVE, SETTLE, DONE} state_e;
`endif

  state_e           state_q;
  logic [PW-1:0]    ptr_q, win_q, win_d;
  logic             op_q;
  logic [AW-1:0]    addr_q;
  logic [3:0]       cnt_q;
  logic [NREQ-1:0]  gnt_q, done_q;
  logic             err_q, busy_q;
  logic [NCELL-1:0] cs_q, cr_q;
  logic             g_op, in_rng, fin_d, fin_err_d;
  logic [AW-1:0]    g_addr;
`ifdef LATCH_BANK_VERIFY_EN
  logic             retry_q, retry_go_d;
`else
  logic             unused_cell_q;
  assign unused_cell_q = ^bus.cell_q;
`endif

  // Out-of-range addresses decode to no line at all, so nothing ever hits the netlist.
  function automatic logic [NCELL-1:0] decode(input logic [AW-1:0] a);
    decode = '0;
    if (int'(a) < NCELL) decode[a] = 1'b1;
  endfunction

  always_comb begin
    win_d = ptr_q;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (bus.req[PW'((int'(ptr_q) + off) % NREQ)])
        win_d = PW'((int'(ptr_q) + off) % NREQ);
    end
  end

  assign g_op   = bus.req_op[win_q];
  assign g_addr = bus.req_addr[int'(win_q)*AW +: AW];
  assign in_rng = int'(addr_q) < NCELL;

  always_comb begin
    fin_d     = 1'b0;
    fin_err_d = !in_rng;
`ifdef LATCH_BANK_VERIFY_EN
    retry_go_d = 1'b0;
    if (state_q == CHECK) begin
      if (!in_rng || bus.cell_q[addr_q] == op_q) fin_d = 1'b1;
      else if (!retry_q)                         retry_go_d = 1'b1;
      else begin
        fin_d     = 1'b1;
        fin_err_d = 1'b1;
      end
    end
`else
    if (state_q == SETTLE && cnt_q == 4'd0) fin_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= '0;
      cr_q    <= '0;
`ifdef LATCH_BANK_VERIFY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (|bus.req) begin
          win_q   <= win_d;
          gnt_q   <= NREQ'(1) << win_d;
          busy_q  <= 1'b1;
          state_q <= GRANT;
        end
        GRANT: begin
          op_q   <= g_op;
          addr_q <= g_addr;
          if (g_op) cs_q <= decode(g_addr);
          else      cr_q <= decode(g_addr);
          cnt_q   <= 4'(DRIVE_CYC - 1);
          state_q <= DRIVE;
`ifdef LATCH_BANK_VERIFY_EN
          retry_q <= 1'b0;
`endif
        end
        DRIVE: if (cnt_q == 4'd0) begin
          cs_q    <= '0;
          cr_q    <= '0;
          cnt_q   <= 4'(SETTLE_CYC - 1);
          state_q <= SETTLE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        SETTLE: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end
`ifdef LATCH_BANK_VERIFY_EN
        else begin
          state_q <= CHECK;
        end
        CHECK: if (retry_go_d) begin
          retry_q <= 1'b1;
          if (op_q) cs_q <= decode(addr_q);
          else      cr_q <= decode(addr_q);
          cnt_q   <= 4'(DRIVE_CYC - 1);
          state_q <= DRIVE;
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Completion overrides the per-state updates above: gnt drops as done rises.
      if (fin_d) begin
        gnt_q   <= '0;
        done_q  <= gnt_q;
        err_q   <= fin_err_d;
        ptr_q   <= PW'((int'(win_q) + 1) % NREQ);
        state_q <= DONE;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.cell_s = cs_q;
  assign bus.cell_r = cr_q;

endmodule

// File: tb/tb_latch_bank_scheduler.sv
// Directed bench for latch_bank_scheduler with a behavioural latch-bank model.
// Expectations adapt to LATCH_BANK_VERIFY_EN through the VER constant.
module tb_latch_bank_scheduler;
  localparam int NR = 4;
  localparam int NC = 8;
  localparam int AWT = 4;
`ifdef LATCH_BANK_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int D1 = 5 + VER;
  localparam int D4 = (VER == 1) ? 10 : 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0] lq = '0;
  logic [NC-1:0] hold0 = '0;
  int checks = 0;
  int failures = 0;
  int viol = 0;

  latch_bank_if #(.NREQ(NR), .NCELL(NC), .AW(AWT)) bus ();

  latch_bank_scheduler #(.NREQ(NR), .NCELL(NC), .AW(AWT), .DRIVE_CYC(1), .SETTLE_CYC(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (bus.cell_s[k])      lq[k] <= 1'b1;
      else if (bus.cell_r[k]) lq[k] <= 1'b0;
    end
  end
  assign bus.cell_q = lq & ~hold0;

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(bus.cell_s | bus.cell_r) > 1) viol++;
      if ((bus.cell_s & bus.cell_r) != '0)        viol++;
      if ($countones(bus.gnt) > 1)                viol++;
      if (bus.err && bus.done == '0)              viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      step();
    end
    chk("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_req(input int i, input logic op, input logic [AWT-1:0] a);
    bus.req[i]                = 1'b1;
    bus.req_op[i]             = op;
    bus.req_addr[i*AWT +: AWT] = a;
  endtask

  initial begin
    int pulses;
    logic [NC-1:0] act;
    bus.req = '0; bus.req_op = '0; bus.req_addr = '0;
    step(); step();
    chk("rst_gnt",  32'(bus.gnt),    32'd0);
    chk("rst_done", 32'(bus.done),   32'd0);
    chk("rst_err",  32'(bus.err),    32'd0);
    chk("rst_busy", 32'(bus.busy),   32'd0);
    chk("rst_s",    32'(bus.cell_s), 32'd0);
    chk("rst_r",    32'(bus.cell_r), 32'd0);
    rst = 1'b0;
    step();

    // single set of cell 5; req dropped mid-transaction must not abort
    set_req(0, 1'b1, 4'd5);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("t1_gnt",  32'(bus.gnt),    (e < D1) ? 32'h1 : 32'h0);
      chk("t1_busy", 32'(bus.busy),   (e <= D1) ? 32'h1 : 32'h0);
      chk("t1_s",    32'(bus.cell_s), (e == 2) ? 32'h20 : 32'h0);
      chk("t1_r",    32'(bus.cell_r), 32'h0);
      chk("t1_done", 32'(bus.done),   (e == D1) ? 32'h1 : 32'h0);
      chk("t1_err",  32'(bus.err),    32'h0);
      if (e == 2) bus.req = '0;
    end

    // round-robin from a fresh pointer with every requester held high
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'(i));
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 20 && bus.gnt == '0; i++) step();
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (t % NR)));
      for (int i = 0; i < 20 && bus.gnt != '0; i++) step();
      chk("rr_done", 32'(bus.done), 32'(1 << (t % NR)));
      if (t == 4) bus.req = '0;
    end
    wait_idle();

    // out-of-range address on requester 1 (pointer now 1)
    set_req(1, 1'b1, 4'd9);
    act = '0;
    for (int e = 1; e <= 8; e++) begin
      step();
      act |= bus.cell_s | bus.cell_r;
      chk("oor_done", 32'(bus.done), (e == D1) ? 32'h2 : 32'h0);
      chk("oor_err",  32'(bus.err),  (e == D1) ? 32'h1 : 32'h0);
      if (e == 1) bus.req = '0;
    end
    chk("oor_drive", 32'(act), 32'h0);
    wait_idle();

    // set of cell 2 while the readback is stuck low
    hold0 = 8'h04;
    set_req(2, 1'b1, 4'd2);
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.cell_s[2]) pulses++;
      chk("vfy_done", 32'(bus.done), (e == D4) ? 32'h4 : 32'h0);
      chk("vfy_err",  32'(bus.err),  (e == D4) ? 32'(VER) : 32'h0);
      if (e == 1) bus.req = '0;
    end
    chk("vfy_pulses", 32'(pulses), 32'(1 + VER));
    hold0 = '0;
    wait_idle();

    // reset during a clear drive of cell 3
    set_req(3, 1'b0, 4'd3);
    step();
    chk("mr_gnt", 32'(bus.gnt), 32'h8);
    step();
    chk("mr_r", 32'(bus.cell_r), 32'h08);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = '0;
    chk("mr_gnt0",  32'(bus.gnt),    32'h0);
    chk("mr_r0",    32'(bus.cell_r), 32'h0);
    chk("mr_s0",    32'(bus.cell_s), 32'h0);
    chk("mr_busy0", 32'(bus.busy),   32'h0);
    chk("mr_err0",  32'(bus.err),    32'h0);
    act = '0;
    for (int e = 0; e < 6; e++) begin
      act[3:0] = act[3:0] | bus.done;
      step();
    end
    chk("mr_nodone", 32'(act), 32'h0);
    set_req(1, 1'b1, 4'd1);
    set_req(3, 1'b1, 4'd4);
    step();
    chk("mr_ptr0", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    wait_idle();

    // random traffic for the exclusion invariants
    for (int c = 0; c < 2000; c++) begin
      bus.req      = 4'($urandom_range(0, 15));
      bus.req_op   = 4'($urandom_range(0, 15));
      bus.req_addr = 16'($urandom_range(0, 65535));
      step();
    end
    bus.req = '0;
    wait_idle();
    chk("excl_viol", 32'(viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
